// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and one long-latency unit.
// Holds a one-entry result buffer, a pending-destination scoreboard and starvation control.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_write_data,
    input  logic            wb_regfile_wr_enable,
    input  logic            lu_valid,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      dec_rs1,
    input  logic [4:0]      dec_rs2,
    input  logic [4:0]      dec_rd,
    output logic            hazard_stall,
    output logic            pipe_stall,
    output logic            rf_wr_enable,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wr_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t          state, state_next;
    logic [3:0]      starve_cnt, starve_cnt_next;
    logic [4:0]      buf_rd, buf_rd_next;
    logic [XLEN-1:0] buf_data, buf_data_next;
    logic [31:0]     pending, pending_clr, pending_set;
    logic            pipe_req, accept, bypass, buf_drain;

    // Port arbitration and write-port drive
    always_comb begin
        pipe_req     = wb_regfile_wr_enable && (wb_rd != 5'd0);
        lu_ready     = (state == EMPTY) && !rst;
        accept       = lu_valid && lu_ready;
        bypass       = 1'b0;
        buf_drain    = 1'b0;
        pipe_stall   = 1'b0;
        rf_wr_enable = 1'b0;
        rf_rd        = 5'd0;
        rf_wr_data   = {XLEN{1'b0}};
        if (!rst) begin
            case (state)
                FORCE: begin
                    buf_drain  = 1'b1;
                    pipe_stall = 1'b1;
                end
                HELD:    buf_drain = !pipe_req;
                EMPTY:   bypass    = accept && !pipe_req && (lu_rd != 5'd0);
                default: buf_drain = 1'b0;
            endcase
            // a forced drain outranks the pipeline, which is frozen for that cycle
            if (buf_drain) begin
                rf_wr_enable = 1'b1;
                rf_rd        = buf_rd;
                rf_wr_data   = buf_data;
            end else if (pipe_req) begin
                rf_wr_enable = 1'b1;
                rf_rd        = wb_rd;
                rf_wr_data   = wb_write_data;
            end else if (bypass) begin
                rf_wr_enable = 1'b1;
                rf_rd        = lu_rd;
                rf_wr_data   = lu_data;
            end else begin
                rf_wr_enable = 1'b0;
            end
        end else begin
            pipe_stall = 1'b0;
        end
    end

    // Buffer state machine and starvation counter next state
    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        buf_rd_next     = buf_rd;
        buf_data_next   = buf_data;
        case (state)
            EMPTY: begin
                if (accept && pipe_req && (lu_rd != 5'd0)) begin
                    state_next      = HELD;
                    starve_cnt_next = 4'd1;
                    buf_rd_next     = lu_rd;
                    buf_data_next   = lu_data;
                end else begin
                    starve_cnt_next = 4'd0;
                end
            end
            HELD: begin
                if (buf_drain) begin
                    state_next      = EMPTY;
                    starve_cnt_next = 4'd0;
                end else if (starve_cnt == LIMIT) begin
                    state_next = FORCE;
                end else begin
                    starve_cnt_next = starve_cnt + 4'd1;
                end
            end
            FORCE: begin
                state_next      = EMPTY;
                starve_cnt_next = 4'd0;
            end
            default: begin
                state_next      = EMPTY;
                starve_cnt_next = 4'd0;
            end
        endcase
    end

    // Scoreboard set/clear vectors; an issue and a completion to the same register leave it pending
    always_comb begin
        pending_clr = 32'd0;
        pending_set = 32'd0;
        if (buf_drain) begin
            pending_clr[buf_rd] = 1'b1;
        end else if (bypass) begin
            pending_clr[lu_rd] = 1'b1;
        end else begin
            pending_clr = 32'd0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            pending_set[issue_rd] = 1'b1;
        end else begin
            pending_set = 32'd0;
        end
        hazard_stall = !rst && (pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd]);
    end

    // State, buffer and scoreboard registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            starve_cnt <= 4'd0;
            buf_rd     <= 5'd0;
            buf_data   <= {XLEN{1'b0}};
            pending    <= 32'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
            buf_rd     <= buf_rd_next;
            buf_data   <= buf_data_next;
            pending    <= (pending & ~pending_clr) | pending_set;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: directed vectors with literal expectations plus a deadline-based
// reference model compared against the arbiter every cycle.
module tb_wb_port_arbiter;

    localparam int XLEN = 32;
    localparam int SL   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      wb_rd, lu_rd, issue_rd, dec_rs1, dec_rs2, dec_rd, rf_rd;
    logic [XLEN-1:0] wb_write_data, lu_data, rf_wr_data;
    logic            wb_regfile_wr_enable, lu_valid, lu_ready, issue_valid;
    logic            hazard_stall, pipe_stall, rf_wr_enable;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(SL)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .wb_rd                (wb_rd),
        .wb_write_data        (wb_write_data),
        .wb_regfile_wr_enable (wb_regfile_wr_enable),
        .lu_valid             (lu_valid),
        .lu_rd                (lu_rd),
        .lu_data              (lu_data),
        .lu_ready             (lu_ready),
        .issue_valid          (issue_valid),
        .issue_rd             (issue_rd),
        .dec_rs1              (dec_rs1),
        .dec_rs2              (dec_rs2),
        .dec_rd               (dec_rd),
        .hazard_stall         (hazard_stall),
        .pipe_stall           (pipe_stall),
        .rf_wr_enable         (rf_wr_enable),
        .rf_rd                (rf_rd),
        .rf_wr_data           (rf_wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_rd = 5'd0; wb_write_data = 32'd0; wb_regfile_wr_enable = 1'b0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
    endtask

    // Reference model: a buffered result must leave exactly SL+1 cycles after acceptance
    // unless the port frees up earlier.
    initial begin
        bit          m_valid, preq, frc, s_buf, s_pipe, s_byp, cap;
        logic [4:0]  m_rd;
        logic [31:0] m_data, m_pend;
        int          m_acc, m_cyc;
        m_valid = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_pend = 32'd0; m_acc = 0; m_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("m_rst_en", 32'(rf_wr_enable), 32'd0);
                check("m_rst_ready", 32'(lu_ready), 32'd0);
                check("m_rst_pstall", 32'(pipe_stall), 32'd0);
                check("m_rst_haz", 32'(hazard_stall), 32'd0);
                m_valid = 1'b0;
                m_pend  = 32'd0;
            end else begin
                preq   = wb_regfile_wr_enable && (wb_rd != 5'd0);
                frc    = m_valid && (m_cyc - m_acc == SL + 1);
                s_buf  = m_valid && (frc || !preq);
                s_pipe = !frc && preq;
                s_byp  = !m_valid && !preq && lu_valid && (lu_rd != 5'd0);
                cap    = !m_valid && preq && lu_valid && (lu_rd != 5'd0);
                check("m_en", 32'(rf_wr_enable), 32'(s_buf | s_pipe | s_byp));
                if (s_buf) begin
                    check("m_buf_rd", 32'(rf_rd), 32'(m_rd));
                    check("m_buf_data", rf_wr_data, m_data);
                end else if (s_pipe) begin
                    check("m_wb_rd", 32'(rf_rd), 32'(wb_rd));
                    check("m_wb_data", rf_wr_data, wb_write_data);
                end else if (s_byp) begin
                    check("m_byp_rd", 32'(rf_rd), 32'(lu_rd));
                    check("m_byp_data", rf_wr_data, lu_data);
                end
                check("m_ready", 32'(lu_ready), 32'(!m_valid));
                check("m_pstall", 32'(pipe_stall), 32'(frc));
                check("m_haz", 32'(hazard_stall),
                      32'(m_pend[dec_rs1] | m_pend[dec_rs2] | m_pend[dec_rd]));
                if (s_buf) begin
                    m_pend[m_rd] = 1'b0;
                    m_valid      = 1'b0;
                end else if (s_byp) begin
                    m_pend[lu_rd] = 1'b0;
                end
                if (cap) begin
                    m_valid = 1'b1; m_rd = lu_rd; m_data = lu_data; m_acc = m_cyc;
                end
                if (issue_valid && (issue_rd != 5'd0)) m_pend[issue_rd] = 1'b1;
            end
            m_cyc++;
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0; #1;
        check("idle_en", 32'(rf_wr_enable), 32'd0);
        check("idle_ready", 32'(lu_ready), 32'd1);
        check("idle_haz", 32'(hazard_stall), 32'd0);
        check("idle_pstall", 32'(pipe_stall), 32'd0);

        // bypass with x5 outstanding
        tick(); issue_valid = 1'b1; issue_rd = 5'd5;
        tick(); idle(); lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hDEADBEEF; dec_rs1 = 5'd5; #1;
        check("byp_en", 32'(rf_wr_enable), 32'd1);
        check("byp_rd", 32'(rf_rd), 32'd5);
        check("byp_data", rf_wr_data, 32'hDEADBEEF);
        check("byp_haz", 32'(hazard_stall), 32'd1);
        tick(); idle(); dec_rs1 = 5'd5; #1;
        check("byp_clr", 32'(hazard_stall), 32'd0);
        check("byp_ready", 32'(lu_ready), 32'd1);

        // conflict: pipeline x3 vs long-latency x7
        tick(); idle();
        wb_regfile_wr_enable = 1'b1; wb_rd = 5'd3; wb_write_data = 32'h11;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h22; #1;
        check("cf0_rd", 32'(rf_rd), 32'd3);
        check("cf0_data", rf_wr_data, 32'h11);
        check("cf0_ready", 32'(lu_ready), 32'd1);
        tick(); idle(); #1;
        check("cf1_en", 32'(rf_wr_enable), 32'd1);
        check("cf1_rd", 32'(rf_rd), 32'd7);
        check("cf1_data", rf_wr_data, 32'h22);
        check("cf1_ready", 32'(lu_ready), 32'd0);
        tick(); #1;
        check("cf2_ready", 32'(lu_ready), 32'd1);
        check("cf2_en", 32'(rf_wr_enable), 32'd0);

        // starvation: pipeline writes x1 every cycle while x9 waits
        tick();
        wb_regfile_wr_enable = 1'b1; wb_rd = 5'd1; wb_write_data = 32'hA0;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99; #1;
        check("st0_rd", 32'(rf_rd), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick(); lu_valid = 1'b0; wb_write_data = 32'hA0 + 32'(i); #1;
            check("st_held_rd", 32'(rf_rd), 32'd1);
            check("st_held_pstall", 32'(pipe_stall), 32'd0);
        end
        tick(); wb_write_data = 32'hA5; #1;
        check("st_force_pstall", 32'(pipe_stall), 32'd1);
        check("st_force_rd", 32'(rf_rd), 32'd9);
        check("st_force_data", rf_wr_data, 32'h99);
        tick(); #1;
        check("st_after_pstall", 32'(pipe_stall), 32'd0);
        check("st_after_rd", 32'(rf_rd), 32'd1);
        check("st_after_data", rf_wr_data, 32'hA5);

        // scoreboard on x12, and x0 issue never stalls
        tick(); idle(); issue_valid = 1'b1; issue_rd = 5'd12;
        tick(); issue_rd = 5'd0; dec_rs2 = 5'd12; #1;
        check("sb_haz1", 32'(hazard_stall), 32'd1);
        tick(); issue_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'hC0FFEE; #1;
        check("sb_haz2", 32'(hazard_stall), 32'd1);
        check("sb_wr_rd", 32'(rf_rd), 32'd12);
        tick(); lu_valid = 1'b0; #1;
        check("sb_clr", 32'(hazard_stall), 32'd0);
        tick(); dec_rs2 = 5'd0; #1;
        check("sb_x0", 32'(hazard_stall), 32'd0);

        // simultaneous issue and completion of x13 keeps it pending
        tick(); issue_valid = 1'b1; issue_rd = 5'd13; lu_valid = 1'b1; lu_rd = 5'd13; lu_data = 32'h1313;
        tick(); idle(); dec_rd = 5'd13; #1;
        check("sw_haz", 32'(hazard_stall), 32'd1);
        lu_valid = 1'b1; lu_rd = 5'd13; lu_data = 32'h1314;
        tick(); idle(); dec_rd = 5'd13; #1;
        check("sw_clr", 32'(hazard_stall), 32'd0);

        // lu_rd==0 is accepted but never buffered
        tick(); idle(); wb_regfile_wr_enable = 1'b1; wb_rd = 5'd6; wb_write_data = 32'h6;
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h5A5A; #1;
        check("z_rd", 32'(rf_rd), 32'd6);
        tick(); idle(); #1;
        check("z_ready", 32'(lu_ready), 32'd1);
        check("z_en", 32'(rf_wr_enable), 32'd0);

        // a pipeline write to x0 does not block the buffer
        tick(); wb_regfile_wr_enable = 1'b1; wb_rd = 5'd6; wb_write_data = 32'h66;
        lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'h1010;
        tick(); idle(); wb_regfile_wr_enable = 1'b1; wb_rd = 5'd0; wb_write_data = 32'hFFFF; #1;
        check("x0_rd", 32'(rf_rd), 32'd10);
        check("x0_data", rf_wr_data, 32'h1010);

        // reset while x4 is held
        tick(); idle(); issue_valid = 1'b1; issue_rd = 5'd4;
        tick(); idle(); wb_regfile_wr_enable = 1'b1; wb_rd = 5'd2; wb_write_data = 32'h2;
        lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h4444;
        tick(); lu_valid = 1'b0; rst = 1'b1; dec_rs1 = 5'd4; #1;
        check("rh_en", 32'(rf_wr_enable), 32'd0);
        check("rh_ready", 32'(lu_ready), 32'd0);
        check("rh_haz", 32'(hazard_stall), 32'd0);
        tick(); rst = 1'b0; idle(); dec_rs1 = 5'd4; #1;
        check("rh_ready_after", 32'(lu_ready), 32'd1);
        check("rh_en_after", 32'(rf_wr_enable), 32'd0);
        check("rh_haz_after", 32'(hazard_stall), 32'd0);
        repeat (SL + 3) tick();

        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
